// File: rtl/alu_exec_core.sv
// Execution core: register file, flag-producing ALU and a byte-serial load/store sequencer.
// ALU ops complete at the accept edge; STORE holds Cmd_Ready low NB cycles, LOAD NB+1 cycles.
module alu_exec_core #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   localparam int RI   = $clog2(NREG)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Cmd_Valid,
   output logic             Cmd_Ready,
   input  logic [3:0]       Cmd_Op,
   input  logic [RI-1:0]    Cmd_Dst,
   input  logic [RI-1:0]    Cmd_SrcA,
   input  logic [RI-1:0]    Cmd_SrcB,
   input  logic [WIDTH-1:0] Cmd_Imm,
   input  logic             Cmd_WF,
   output logic [3:0]       Flags,
   output logic             Mem_En,
   output logic             Mem_WE,
   output logic [15:0]      Mem_Addr,
   output logic [7:0]       Mem_WData,
   input  logic [7:0]       Mem_RData,
   input  logic [RI-1:0]    Dbg_Sel,
   output logic [WIDTH-1:0] Dbg_Data
);

   localparam int NB = WIDTH / 8;
   localparam int CW = $clog2(NB + 1);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_MOVI  = 4'd0;
   localparam logic [3:0] OP_MOV   = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_ADC   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_NOT   = 4'd8;
   localparam logic [3:0] OP_LSL   = 4'd9;
   localparam logic [3:0] OP_LSR   = 4'd10;
   localparam logic [3:0] OP_ASR   = 4'd11;
   localparam logic [3:0] OP_ROL   = 4'd12;
   localparam logic [3:0] OP_LOAD  = 4'd13;
   localparam logic [3:0] OP_STORE = 4'd14;

   typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] regs [NREG];
   logic [CW-1:0]    idx;
   logic [15:0]      addr;
   logic [WIDTH-1:0] sdata;
   logic [WIDTH-1:0] ldata;
   logic [RI-1:0]    ld_dst;

   logic             accept;
   logic             st_last;
   logic             ld_done;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [WIDTH-1:0] res;
   logic             c_new;
   logic             o_new;
   logic             wr_reg;
   logic             flag_op;
   logic [WIDTH+15:0] imm_pad;
   logic [WIDTH+7:0]  ld_cat;
   logic [WIDTH+7:0]  st_cat;
   logic [WIDTH-1:0]  ld_next;
   logic [WIDTH-1:0]  st_next;
   logic              unused_bits;

   assign accept   = Cmd_Valid & Cmd_Ready;
   assign st_last  = (idx == CW'(NB - 1));
   assign ld_done  = (idx == CW'(NB));
   assign a        = regs[Cmd_SrcA];
   assign b        = regs[Cmd_SrcB];
   assign cin      = Flags[2];
   assign Dbg_Data = regs[Dbg_Sel];

   // Little-endian assembly: each byte enters at the top and drifts down to its lane.
   assign imm_pad = {16'h0000, Cmd_Imm};
   assign ld_cat  = {Mem_RData, ldata};
   assign ld_next = ld_cat[WIDTH+7:8];
   assign st_cat  = {8'h00, sdata};
   assign st_next = st_cat[WIDTH+7:8];
   assign unused_bits = ^{imm_pad[WIDTH+15:16], ld_cat[7:0], st_cat[7:0]};

   assign sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (Cmd_Op == OP_ADC) & cin};
   assign sum_sub = {1'b0, a} - {1'b0, b};

   always_comb begin
      res     = '0;
      c_new   = Flags[2];
      o_new   = Flags[0];
      wr_reg  = 1'b1;
      flag_op = 1'b1;
      case (Cmd_Op)
         OP_MOVI: begin res = Cmd_Imm; flag_op = 1'b0; end
         OP_MOV:  begin res = a;       flag_op = 1'b0; end
         OP_ADD, OP_ADC: begin
            res   = sum_add[WIDTH-1:0];
            c_new = sum_add[WIDTH];
            o_new = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
         end
         OP_SUB: begin
            res   = sum_sub[WIDTH-1:0];
            c_new = ~sum_sub[WIDTH];
            o_new = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         OP_LSL: begin res = {a[WIDTH-2:0], 1'b0}; c_new = a[MSB]; end
         OP_LSR: begin res = {1'b0, a[WIDTH-1:1]}; c_new = a[0];   end
         OP_ASR: begin res = {a[MSB], a[WIDTH-1:1]}; c_new = a[0]; end
         OP_ROL: begin res = {a[WIDTH-2:0], cin};  c_new = a[MSB]; end
         default: begin wr_reg = 1'b0; flag_op = 1'b0; end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && Cmd_Op == OP_STORE)     state_nxt = S_STORE;
            else if (accept && Cmd_Op == OP_LOAD) state_nxt = S_LOAD;
         end
         S_STORE: if (st_last) state_nxt = S_IDLE;
         S_LOAD:  if (ld_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      Cmd_Ready = (state == S_IDLE);
      Mem_En    = (state == S_STORE) || (state == S_LOAD && !ld_done);
      Mem_WE    = (state == S_STORE);
      Mem_Addr  = Mem_En ? addr : 16'h0000;
      Mem_WData = (state == S_STORE) ? sdata[7:0] : 8'h00;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         idx    <= '0;
         addr   <= '0;
         sdata  <= '0;
         ldata  <= '0;
         ld_dst <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  idx    <= '0;
                  addr   <= imm_pad[15:0];
                  sdata  <= a;
                  ld_dst <= Cmd_Dst;
               end
            end
            S_STORE: begin
               idx   <= idx + 1'b1;
               addr  <= addr + 16'd1;
               sdata <= st_next;
            end
            S_LOAD: begin
               idx <= idx + 1'b1;
               if (!ld_done) addr  <= addr + 16'd1;
               if (idx != '0) ldata <= ld_next;
            end
            default: idx <= '0;
         endcase
      end
   end

   // A load only commits at its final edge, so a reset mid-load leaves Dst untouched.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         Flags <= 4'h0;
      end else begin
         if (accept && wr_reg)
            regs[Cmd_Dst] <= res;
         else if (state == S_LOAD && ld_done)
            regs[ld_dst] <= ld_next;
         if (accept && flag_op && Cmd_WF)
            Flags <= {~|res, c_new, res[MSB], o_new};
      end
   end

endmodule

// File: tb/tb_alu_exec_core.sv
// Bench for alu_exec_core: random command streams against an arithmetic reference model,
// plus directed boundary scenarios on a 16-bit/8-reg and a 32-bit/4-reg instance.
module tb_alu_exec_core;

   localparam int W   = 16;
   localparam int NBY = 2;
   localparam longint unsigned MASK = 64'hFFFF;
   localparam longint unsigned HALF = 64'h8000;

   logic clk = 1'b0;
   logic rst_n;
   logic rst2_n;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_wf;
   logic [3:0]  cmd_op;
   logic [2:0]  cmd_dst, cmd_src_a, cmd_src_b, dbg_sel;
   logic [15:0] cmd_imm, dbg_data;
   logic [3:0]  flags;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   logic        v2, rdy2, wf2, men2, mwe2;
   logic [3:0]  op2, fl2;
   logic [1:0]  dst2, sa2, sb2, dsel2;
   logic [31:0] imm2, dbg2;
   logic [15:0] maddr2;
   logic [7:0]  mwd2, rdat2;

   alu_exec_core #(.WIDTH(16), .NREG(8)) u_dut (
      .Clock(clk), .Reset(rst_n), .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready),
      .Cmd_Op(cmd_op), .Cmd_Dst(cmd_dst), .Cmd_SrcA(cmd_src_a), .Cmd_SrcB(cmd_src_b),
      .Cmd_Imm(cmd_imm), .Cmd_WF(cmd_wf), .Flags(flags), .Mem_En(mem_en), .Mem_WE(mem_we),
      .Mem_Addr(mem_addr), .Mem_WData(mem_wdata), .Mem_RData(mem_rdata),
      .Dbg_Sel(dbg_sel), .Dbg_Data(dbg_data));

   alu_exec_core #(.WIDTH(32), .NREG(4)) u_dut32 (
      .Clock(clk), .Reset(rst2_n), .Cmd_Valid(v2), .Cmd_Ready(rdy2),
      .Cmd_Op(op2), .Cmd_Dst(dst2), .Cmd_SrcA(sa2), .Cmd_SrcB(sb2),
      .Cmd_Imm(imm2), .Cmd_WF(wf2), .Flags(fl2), .Mem_En(men2), .Mem_WE(mwe2),
      .Mem_Addr(maddr2), .Mem_WData(mwd2), .Mem_RData(rdat2),
      .Dbg_Sel(dsel2), .Dbg_Data(dbg2));

   // Byte-wide memory with one-cycle read latency
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   longint unsigned mreg [8];
   logic [3:0]      mflags;

   function automatic longint sv(input longint unsigned x);
      return (x >= HALF) ? longint'(x) - longint'(MASK + 1) : longint'(x);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mreg[i] = 0;
      mflags = 4'h0;
   endtask

   // Flags {Z,C,N,O} from plain integer arithmetic on the word values
   task automatic model_alu(input int op, input int dst, input int sa, input int sb,
                            input longint unsigned imm, input bit wf);
      longint unsigned a, b, r, cin;
      bit c, o;
      a = mreg[sa]; b = mreg[sb]; cin = longint'(mflags[2]);
      c = mflags[2]; o = mflags[0]; r = 0;
      case (op)
         0:  r = imm & MASK;
         1:  r = a;
         2:  begin r = (a + b) & MASK; c = (a + b) > MASK; o = (sv(a) + sv(b)) != sv(r); end
         3:  begin r = (a + b + cin) & MASK; c = (a + b + cin) > MASK;
                   o = (sv(a) + sv(b) + longint'(cin)) != sv(r); end
         4:  begin r = (a - b) & MASK; c = (a >= b); o = (sv(a) - sv(b)) != sv(r); end
         5:  r = a & b;
         6:  r = a | b;
         7:  r = a ^ b;
         8:  r = (~a) & MASK;
         9:  begin r = (a * 2) & MASK; c = (a >= HALF); end
         10: begin r = a / 2; c = (a % 2) == 1; end
         11: begin r = longint'(sv(a) >>> 1) & MASK; c = (a % 2) == 1; end
         12: begin r = (a * 2 + cin) & MASK; c = (a >= HALF); end
         default: r = 0;
      endcase
      if (op <= 12) mreg[dst] = r;
      if (op >= 2 && op <= 12 && wf) mflags = {r == 0, c, r >= HALF, o};
   endtask

   task automatic check_all_regs(input string tag);
      for (int r = 0; r < 8; r++) begin
         dbg_sel = 3'(r);
         #1;
         check(tag, dbg_data, mreg[r]);
      end
   endtask

   task automatic send(input int op, input int dst, input int sa, input int sb,
                       input longint unsigned imm, input bit wf, input bit poke);
      longint unsigned sval, lval;
      int base, k;
      base = int'(imm & MASK);
      sval = mreg[sa];
      k = 0;
      while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
      if (!cmd_ready) check("ready_wait_timeout", 0, 1);
      cmd_valid = 1'b1; cmd_op = 4'(op); cmd_dst = 3'(dst);
      cmd_src_a = 3'(sa); cmd_src_b = 3'(sb); cmd_imm = 16'(imm); cmd_wf = wf;
      @(posedge clk); #1;
      if (poke) begin cmd_op = 4'd0; cmd_imm = 16'h1234; end
      else cmd_valid = 1'b0;
      if (op == 13 || op == 14) begin
         k = 0;
         while (!cmd_ready && k < 20) begin
            if (op == 14) begin
               check("st_en", mem_en, 1); check("st_we", mem_we, 1);
               check("st_addr", mem_addr, (base + k) & 'hFFFF);
               check("st_wdata", mem_wdata, (sval >> (8 * k)) & 'hFF);
            end else if (k < NBY) begin
               check("ld_en", mem_en, 1); check("ld_we", mem_we, 0);
               check("ld_addr", mem_addr, (base + k) & 'hFFFF);
            end else check("ld_tail_en", mem_en, 0);
            @(posedge clk); #1;
            k++;
         end
         cmd_valid = 1'b0;
         check(op == 14 ? "st_busy_cycles" : "ld_busy_cycles", k, op == 14 ? NBY : NBY + 1);
         check("idle_mem_en", mem_en, 0);
         check("idle_mem_addr", mem_addr, 0);
         if (op == 14) begin
            for (int i = 0; i < NBY; i++)
               check("st_mem_byte", mem[(base + i) & 'hFFFF], (sval >> (8 * i)) & 'hFF);
         end else begin
            lval = 0;
            for (int i = 0; i < NBY; i++)
               lval = lval | (longint'(mem[(base + i) & 'hFFFF]) << (8 * i));
            mreg[dst] = lval;
         end
      end else model_alu(op, dst, sa, sb, imm, wf);
      dbg_sel = 3'(dst);
      #1;
      check("dst_reg", dbg_data, mreg[dst]);
      check("flags", flags, mflags);
   endtask

   task automatic send32(input int op, input int dst, input int sa, input int sb,
                         input logic [31:0] imm, input bit wf);
      v2 = 1'b1; op2 = 4'(op); dst2 = 2'(dst); sa2 = 2'(sa); sb2 = 2'(sb); imm2 = imm; wf2 = wf;
      @(posedge clk); #1;
      v2 = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_a [4];
      logic [7:0]  exp_d [4];
      int k, op, r;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem_rdata = 8'h00; rdat2 = 8'h00;
      cmd_valid = 0; cmd_op = 0; cmd_dst = 0; cmd_src_a = 0; cmd_src_b = 0;
      cmd_imm = 0; cmd_wf = 0; dbg_sel = 0;
      v2 = 0; op2 = 0; dst2 = 0; sa2 = 0; sb2 = 0; imm2 = 0; wf2 = 0; dsel2 = 0;
      rst_n = 0; rst2_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", cmd_ready, 1);
      check("rst_flags", flags, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      rst_n = 1; rst2_n = 1;

      // Some activity, then a mid-run reset
      for (int i = 0; i < 10; i++)
         send($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom, 1, 0);
      rst_n = 0;
      #2;
      model_reset();
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_flags", flags, 0);
      check("mid_rst_mem_en", mem_en, 0);
      @(posedge clk); #3;
      rst_n = 1;
      check_all_regs("post_rst_reg");

      // Overflow into the sign bit, then a borrowing subtract
      send(0, 1, 0, 0, 'h7FFF, 0, 0);
      send(0, 2, 0, 0, 'h0001, 0, 0);
      send(2, 3, 1, 2, 0, 1, 0);
      check("add_r3", dbg_data, 16'h8000);
      check("add_flags", flags, 4'b0011);
      send(4, 4, 2, 1, 0, 1, 0);
      check("sub_r4", dbg_data, 16'h8002);
      check("sub_flags", flags, 4'b0010);

      // Shift with flags disabled leaves them alone
      send(0, 5, 0, 0, 'h0001, 0, 0);
      send(10, 6, 5, 0, 0, 0, 0);
      check("lsr_nowf_r6", dbg_data, 16'h0000);
      check("lsr_nowf_flags", flags, 4'b0010);
      send(10, 6, 5, 0, 0, 1, 0);
      check("lsr_wf_flags", flags, 4'b1100);

      // Store and reload across the 0xFFFF address wrap
      send(14, 0, 3, 0, 'hFFFF, 0, 0);
      check("wrap_mem_ffff", mem[16'hFFFF], 8'h00);
      check("wrap_mem_0000", mem[16'h0000], 8'h80);
      send(13, 7, 0, 0, 'hFFFF, 0, 1);
      check("load_r7", dbg_data, 16'h8000);

      // Reset during load cycle 1
      cmd_valid = 1; cmd_op = 4'd13; cmd_dst = 3'd7; cmd_src_a = 0; cmd_imm = 16'h0100;
      @(posedge clk); #1;
      cmd_valid = 0;
      @(posedge clk); #1;
      check("ld_c1_en", mem_en, 1);
      rst_n = 0;
      #1;
      check("ld_rst_en_drop", mem_en, 0);
      model_reset();
      @(posedge clk); #3;
      rst_n = 1;
      check("ld_rst_ready", cmd_ready, 1);
      dbg_sel = 3'd7;
      #1;
      check("ld_rst_r7", dbg_data, 16'h0000);

      // Random command stream
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 21);
         op = (r <= 15) ? r : $urandom_range(2, 12);
         send(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              longint'($urandom_range(0, 65535)), 1'($urandom), (op == 13) ? 1'($urandom) : 1'b0);
      end
      check_all_regs("final_reg");

      // 32-bit, 4-register instance
      send32(0, 1, 0, 0, 32'h7FFF_FFFF, 0);
      send32(0, 2, 0, 0, 32'h0000_0001, 0);
      send32(2, 3, 1, 2, 32'h0, 1);
      dsel2 = 2'd3;
      #1;
      check("w32_add_r3", dbg2, 32'h8000_0000);
      check("w32_add_flags", fl2, 4'b0011);
      send32(4, 0, 2, 1, 32'h0, 1);
      dsel2 = 2'd0;
      #1;
      check("w32_sub_r0", dbg2, 32'h8000_0002);
      check("w32_sub_flags", fl2, 4'b0010);
      exp_a[0] = 16'hFFFF; exp_a[1] = 16'h0000; exp_a[2] = 16'h0001; exp_a[3] = 16'h0002;
      exp_d[0] = 8'h02;    exp_d[1] = 8'h00;    exp_d[2] = 8'h00;    exp_d[3] = 8'h80;
      send32(14, 0, 0, 0, 32'h0000_FFFF, 0);
      k = 0;
      while (!rdy2 && k < 20) begin
         if (k < 4) begin
            check("w32_st_en", men2, 1); check("w32_st_we", mwe2, 1);
            check("w32_st_addr", maddr2, exp_a[k]); check("w32_st_wdata", mwd2, exp_d[k]);
         end
         @(posedge clk); #1;
         k++;
      end
      check("w32_st_busy_cycles", k, 4);
      check("w32_idle_mem_en", men2, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_exec_core.md
# alu_exec_core

Parametrised successor to the 16-bit ALU datapath: a self-contained execution core with an `NREG`×`WIDTH` register file, a flag-producing ALU and a byte-serial load/store sequencer onto the 8-bit memory bus. Commands arrive over a valid/ready handshake. ALU commands complete in one cycle; loads and stores take multiple cycles. The block sits between the instruction-decode/control logic and the byte-wide Memory.

## Interface
- `WIDTH`, 16: datapath width. Multiple of 8, range 8..64. `NB = WIDTH/8` bytes per word.
- `NREG`, 8: register count. Power of two, range 2..16. `RI = $clog2(NREG)`.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  active-low reset. Asynchronous assert, synchronous release.
- `Cmd_Valid`  in  1  command present.
- `Cmd_Ready`  out  1  core can accept a command.
- `Cmd_Op`  in  4  opcode (see Operation).
- `Cmd_Dst`, `Cmd_SrcA`, `Cmd_SrcB`  in  RI  register indices.
- `Cmd_Imm`  in  WIDTH  immediate. Bits [15:0] are the memory base address for LOAD/STORE.
- `Cmd_WF`  in  1  write-flags enable.
- `Flags`  out  4  {Z,C,N,O}.
- `Mem_En`  out  1  memory access this cycle.
- `Mem_WE`  out  1  1 = write, 0 = read.
- `Mem_Addr`  out  16  byte address.
- `Mem_WData`  out  8  write byte.
- `Mem_RData`  in  8  read byte, valid one cycle after a read request.
- `Dbg_Sel`  in  RI  debug register select.
- `Dbg_Data`  out  WIDTH  combinational read of register `Dbg_Sel`.

## Operation
Opcodes. A = R[SrcA], B = R[SrcB].
- 0 MOVI: Dst ← Imm
- 1 MOV: Dst ← A
- 2 ADD: A+B
- 3 ADC: A+B+C
- 4 SUB: A−B
- 5 AND
- 6 OR
- 7 XOR
- 8 NOT A
- 9 LSL A
- 10 LSR A
- 11 ASR A
- 12 ROL A: rotate left through C
- 13 LOAD: Dst ← NB bytes from Imm[15:0]
- 14 STORE: write A to Imm[15:0]
- 15 NOP

Command acceptance:
- A command is accepted at a rising edge where `Cmd_Valid & Cmd_Ready` is high.
- Command fields are sampled only at the accept edge.
- `Cmd_Valid` while `Cmd_Ready`=0 is ignored. The core never latches a pending command.

Flags:
- Flags update only for ops 2..12, and only when `Cmd_WF`=1. No other op touches flags.
- Z and N are updated by every op in 2..12. N = result MSB.
- ADD/ADC: C = carry out; O = signed overflow.
- SUB: C = 1 when there is no borrow (A ≥ B unsigned); O = signed overflow.
- Logic ops (5..8): C and O unchanged.
- Shifts and rotate: C = the bit shifted out; O unchanged.

Arithmetic and memory rules:
- All results are truncated to WIDTH.
- Byte order is little-endian: byte i sits at address base+i.
- Addresses are mod 2^16, so 0xFFFF+1 wraps to 0x0000.

State machine, states IDLE / STORE / LOAD:
- IDLE:
  - `Cmd_Ready`=1.
  - Ops 0..12 write Dst at the accept edge and stay in IDLE.
  - NOP stays in IDLE.
  - STORE goes to STORE with i=0. LOAD goes to LOAD with i=0.
- STORE, i = 0..NB−1, one byte per cycle:
  - Mem_En=1, Mem_WE=1, Mem_Addr=base+i, Mem_WData=A[8i+7:8i].
  - A is captured at the accept edge.
  - After byte NB−1, return to IDLE.
- LOAD, cycles 0..NB:
  - In cycle i < NB, issue a read: Mem_En=1, Mem_WE=0, Mem_Addr=base+i.
  - In cycle i ≥ 1, capture `Mem_RData` into byte i−1.
  - Dst is written at the edge ending cycle NB, then return to IDLE.
- Register reads are combinational from current state. A command accepted on the cycle after a write sees the new value, with no stall.
- Dst = SrcA on LOAD is permitted.
- Outside STORE/LOAD: Mem_En=0, Mem_WE=0, Mem_Addr=0, Mem_WData=0.

## Timing
- Reset values:
  - All registers 0; Flags 0; state IDLE.
  - Cmd_Ready=1.
  - Mem_En=0, Mem_WE=0, Mem_Addr=0, Mem_WData=0.
- Reset mid-operation aborts at once (asynchronous):
  - Mem_En drops in the same instant.
  - A partial LOAD is discarded and Dst is unchanged.
  - Bytes already stored by a STORE remain in memory.
- ALU ops:
  - Latency 1: result is visible on `Dbg_Data` after the accept edge.
  - Throughput is 1 per cycle.
- STORE: `Cmd_Ready` is low for NB cycles.
- LOAD: `Cmd_Ready` is low for NB+1 cycles.
- `Cmd_Ready` is high again on the cycle after the last memory cycle.
- Memory outputs are registered (driven from state).

## Test plan
1. Reset: assert `Reset`=0 mid-run, release → `Cmd_Ready`=1, `Flags`=0000, `Mem_En`=0, every `Dbg_Data`=0x0000.
2. MOVI R1=0x7FFF, MOVI R2=0x0001, ADD R3=R1+R2 with WF=1, all back-to-back → R3=0x8000, Z=0 C=0 N=1 O=1. Then SUB R4=R2−R1 with WF=1 → R4=0x8002, C=0 N=1 O=0.
3. Flag hold: MOVI R5=0x0001, then LSR R6=R5 with WF=0 → R6=0, Flags unchanged. Repeat with WF=1 → Z=1, C=1.
4. STORE R3 at Imm=0xFFFF → two write cycles: (0xFFFF, 0x00), then (0x0000, 0x80). `Cmd_Ready` low for exactly 2 cycles.
5. LOAD R7 from 0xFFFF against a memory model → reads at 0xFFFF then 0x0000, `Cmd_Ready` low 3 cycles, R7=0x8000. `Cmd_Valid` pulses during the LOAD are ignored.
6. Reset pulse during LOAD cycle 1 → `Mem_En`=0 immediately, R7 stays 0, `Cmd_Ready`=1 after release. Repeat scenarios 2 and 4 with WIDTH=32, NREG=4: STORE emits 4 bytes, little-endian.
